// File: rtl/branch_checkpoint_table_pkg.sv
// Shared definitions for the branch checkpoint table.
// Contents: default table depth, default physical register file size,
// the architectural register count and the per-entry state encoding.
package branch_checkpoint_table_pkg;

  localparam int BCT_NUM_CKPT  = 4;
  localparam int BCT_NUM_PR    = 64;
  localparam int NUM_ARCH_REGS = 32;

  typedef enum logic [1:0] {
    CKPT_FREE,
    CKPT_PENDING,
    CKPT_RESOLVED
  } ckpt_state_e;

endpackage

// File: rtl/branch_checkpoint_table_storage.sv
// Snapshot storage for the branch checkpoint table (checkpoint_storage).
// NUM_CKPT snapshots of the 32-entry register mapping table.
// Ports:
//   clk      rising-edge clock
//   wr_en    write wr_data into entry wr_idx at the clock edge
//   wr_idx   entry being allocated (table tail)
//   wr_data  snapshot from rename
//   rd_idx   entry being resolved
//   rd_data  combinational read of entry rd_idx
// Contents are not reset; an entry is only read after it has been written.
module branch_checkpoint_table_storage
  import branch_checkpoint_table_pkg::*;
#(
  parameter int NUM_CKPT = BCT_NUM_CKPT,
  parameter int PR_W     = $clog2(BCT_NUM_PR),
  parameter int CKPT_W   = $clog2(NUM_CKPT)
) (
  input  logic                                clk,
  input  logic                                wr_en,
  input  logic [CKPT_W-1:0]                   wr_idx,
  input  logic [NUM_ARCH_REGS-1:0][PR_W-1:0]  wr_data,
  input  logic [CKPT_W-1:0]                   rd_idx,
  output logic [NUM_ARCH_REGS-1:0][PR_W-1:0]  rd_data
);

  logic [NUM_ARCH_REGS-1:0][PR_W-1:0] mem [NUM_CKPT];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= wr_data;
  end

  assign rd_data = mem[rd_idx];

endmodule

// File: rtl/branch_checkpoint_table.sv
// Branch checkpoint table: circular buffer of register-mapping-table
// snapshots taken when branches are renamed.
// Ports:
//   clk, reset_n         clock, synchronous active-low reset
//   ext_stall            blocks allocation
//   ext_flush            frees every entry, no recall
//   alloc_valid          rename requests a checkpoint for a branch
//   checkpointed_rmt     snapshot to store
//   alloc_ready          allocation accepted this cycle (combinational)
//   alloc_tag            tag handed to the allocating branch (tail)
//   resolve_valid/_tag   a branch resolved, and its tag
//   resolve_mispredict   the resolved branch was mispredicted
//   if_recall            one-cycle pulse: restore recalled_rmt
//   recalled_rmt         snapshot being restored
//   ckpt_count           occupied entries; full / empty derived from it
module branch_checkpoint_table
  import branch_checkpoint_table_pkg::*;
#(
  parameter int NUM_CKPT = BCT_NUM_CKPT,
  parameter int PR_W     = $clog2(BCT_NUM_PR),
  parameter int CKPT_W   = $clog2(NUM_CKPT)
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic                                ext_stall,
  input  logic                                ext_flush,
  input  logic                                alloc_valid,
  input  logic [NUM_ARCH_REGS-1:0][PR_W-1:0]  checkpointed_rmt,
  output logic                                alloc_ready,
  output logic [CKPT_W-1:0]                   alloc_tag,
  input  logic                                resolve_valid,
  input  logic [CKPT_W-1:0]                   resolve_tag,
  input  logic                                resolve_mispredict,
  output logic                                if_recall,
  output logic [NUM_ARCH_REGS-1:0][PR_W-1:0]  recalled_rmt,
  output logic [CKPT_W:0]                     ckpt_count,
  output logic                                full,
  output logic                                empty
);

  ckpt_state_e         state [NUM_CKPT];
  logic [CKPT_W-1:0]   head, tail;
  logic [CKPT_W:0]     count;

  logic [NUM_ARCH_REGS-1:0][PR_W-1:0] rd_rmt;

  logic                tag_pending;
  logic                do_mispredict, do_resolve, do_retire, do_alloc;
  logic [CKPT_W-1:0]   tag_age;
  logic [NUM_CKPT-1:0] squash;

  assign full       = (count == (CKPT_W+1)'(NUM_CKPT));
  assign empty      = (count == '0);
  assign ckpt_count = count;
  assign alloc_tag  = tail;

  // A same-cycle mispredict makes any allocation younger than the branch.
  assign alloc_ready = !full && !ext_stall && !if_recall &&
                       !(resolve_valid && resolve_mispredict);

  // Resolves on FREE or RESOLVED entries are ignored.
  assign tag_pending   = (state[resolve_tag] == CKPT_PENDING);
  assign do_mispredict = resolve_valid && resolve_mispredict && tag_pending;
  assign do_resolve    = resolve_valid && !resolve_mispredict && tag_pending;
  assign do_retire     = (state[head] == CKPT_RESOLVED);
  assign do_alloc      = alloc_valid && alloc_ready;

  // Age relative to head: everything at or younger than the mispredicted
  // tag is squashed. Entries outside the occupied window are already FREE.
  always_comb begin
    tag_age = resolve_tag - head;
    for (int i = 0; i < NUM_CKPT; i++) begin
      squash[i] = ((CKPT_W'(i) - head) >= tag_age);
    end
  end

  branch_checkpoint_table_storage #(
    .NUM_CKPT (NUM_CKPT),
    .PR_W     (PR_W),
    .CKPT_W   (CKPT_W)
  ) u_checkpoint_storage (
    .clk     (clk),
    .wr_en   (do_alloc),
    .wr_idx  (tail),
    .wr_data (checkpointed_rmt),
    .rd_idx  (resolve_tag),
    .rd_data (rd_rmt)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_CKPT; i++) state[i] <= CKPT_FREE;
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      if_recall <= 1'b0;
      for (int i = 0; i < NUM_ARCH_REGS; i++) recalled_rmt[i] <= PR_W'(i);
    end else begin
      if_recall <= 1'b0;
      if (ext_flush) begin
        for (int i = 0; i < NUM_CKPT; i++) state[i] <= CKPT_FREE;
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else if (do_mispredict) begin
        // Mispredict outranks retire; head stays put, so the new count is
        // just the distance from head to the mispredicted tag.
        for (int i = 0; i < NUM_CKPT; i++) begin
          if (squash[i]) state[i] <= CKPT_FREE;
        end
        tail         <= resolve_tag;
        count        <= {1'b0, tag_age};
        if_recall    <= 1'b1;
        recalled_rmt <= rd_rmt;
      end else begin
        if (do_resolve) state[resolve_tag] <= CKPT_RESOLVED;
        if (do_retire) begin
          state[head] <= CKPT_FREE;
          head        <= head + 1'b1;
        end
        if (do_alloc) begin
          state[tail] <= CKPT_PENDING;
          tail        <= tail + 1'b1;
        end
        case ({do_alloc, do_retire})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_branch_checkpoint_table.sv
// Bench for branch_checkpoint_table: a table of per-cycle vectors for the
// directed corner cases, then random traffic against a queue-based model.
module tb_branch_checkpoint_table;
  import branch_checkpoint_table_pkg::*;

  localparam int N      = 4;
  localparam int PR_W   = 6;
  localparam int CKPT_W = 2;

  typedef logic [NUM_ARCH_REGS-1:0][PR_W-1:0] rmt_t;

  logic              clk = 1'b0;
  logic              reset_n, ext_stall, ext_flush, alloc_valid;
  rmt_t              checkpointed_rmt;
  logic              alloc_ready;
  logic [CKPT_W-1:0] alloc_tag;
  logic              resolve_valid, resolve_mispredict;
  logic [CKPT_W-1:0] resolve_tag;
  logic              if_recall;
  rmt_t              recalled_rmt;
  logic [CKPT_W:0]   ckpt_count;
  logic              full, empty;

  always #5 clk = ~clk;

  branch_checkpoint_table #(.NUM_CKPT(N), .PR_W(PR_W), .CKPT_W(CKPT_W)) dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .ext_stall          (ext_stall),
    .ext_flush          (ext_flush),
    .alloc_valid        (alloc_valid),
    .checkpointed_rmt   (checkpointed_rmt),
    .alloc_ready        (alloc_ready),
    .alloc_tag          (alloc_tag),
    .resolve_valid      (resolve_valid),
    .resolve_tag        (resolve_tag),
    .resolve_mispredict (resolve_mispredict),
    .if_recall          (if_recall),
    .recalled_rmt       (recalled_rmt),
    .ckpt_count         (ckpt_count),
    .full               (full),
    .empty              (empty)
  );

  int n_cmp = 0;
  int n_bad = 0;

  function automatic rmt_t snap(int id);
    rmt_t r;
    for (int i = 0; i < NUM_ARCH_REGS; i++) r[i] = PR_W'(id * 5 + i * 2 + 3);
    return r;
  endfunction

  function automatic rmt_t ident();
    rmt_t r;
    for (int i = 0; i < NUM_ARCH_REGS; i++) r[i] = PR_W'(i);
    return r;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_outputs(string where, bit rdy, int tag, int cnt, bit rc, rmt_t rmt);
    chk({where, " alloc_ready"}, 32'(alloc_ready), 32'(rdy));
    chk({where, " alloc_tag"},   32'(alloc_tag),   32'(tag));
    chk({where, " ckpt_count"},  32'(ckpt_count),  32'(cnt));
    chk({where, " full"},        32'(full),        32'(cnt == N));
    chk({where, " empty"},       32'(empty),       32'(cnt == 0));
    chk({where, " if_recall"},   32'(if_recall),   32'(rc));
    n_cmp++;
    if (recalled_rmt !== rmt) begin
      n_bad++;
      $display("FAIL %s recalled_rmt: got %h expected %h", where, recalled_rmt, rmt);
    end
  endtask

  task automatic idle();
    ext_stall = 0; ext_flush = 0; alloc_valid = 0;
    resolve_valid = 0; resolve_tag = '0; resolve_mispredict = 0;
    checkpointed_rmt = '0;
  endtask

  // ---------------- directed vector table ----------------
  // One row per cycle: inputs, then expected outputs sampled before the edge.
  // rid is the snapshot id expected on recalled_rmt (0 = reset identity).
  typedef struct {
    bit rst; bit av; int id; bit st; bit fl;
    bit rv; int rt; bit rm;
    bit rdy; int tag; int cnt; bit rc; int rid;
  } vec_t;

  vec_t tv[$];

  task automatic add(bit rst, bit av, int id, bit st, bit fl, bit rv, int rt, bit rm,
                     bit rdy, int tag, int cnt, bit rc, int rid);
    vec_t v;
    v.rst = rst; v.av = av; v.id = id; v.st = st; v.fl = fl;
    v.rv = rv; v.rt = rt; v.rm = rm;
    v.rdy = rdy; v.tag = tag; v.cnt = cnt; v.rc = rc; v.rid = rid;
    tv.push_back(v);
  endtask

  // ---------------- behavioural model ----------------
  // Live checkpoints kept oldest-first; tag of element k is (m_head+k)%N.
  typedef struct { rmt_t snap; bit resolved; } ent_t;
  ent_t mq[$];
  int   m_head;
  bit   m_recall;
  rmt_t m_rmt;

  function automatic bit m_ready();
    return (mq.size() < N) && !ext_stall && !m_recall &&
           !(resolve_valid && resolve_mispredict);
  endfunction

  task automatic model_step();
    int   pos;
    bit   pend, ret, rdy;
    ent_t e;
    rdy  = m_ready();
    pos  = (int'(resolve_tag) - m_head + N) % N;
    pend = (pos < mq.size()) && !mq[pos].resolved;
    if (resolve_valid)
      assert (pend) else $error("resolve on a tag that is not PENDING");
    if (ext_flush) begin
      mq.delete(); m_head = 0; m_recall = 0;
    end else if (resolve_valid && resolve_mispredict && pend) begin
      m_rmt = mq[pos].snap;
      while (mq.size() > pos) void'(mq.pop_back());
      m_recall = 1;
    end else begin
      m_recall = 0;
      ret = (mq.size() > 0) && mq[0].resolved;
      if (resolve_valid && !resolve_mispredict && pend) mq[pos].resolved = 1;
      if (alloc_valid && rdy) begin
        e.snap = checkpointed_rmt; e.resolved = 0;
        mq.push_back(e);
      end
      if (ret) begin
        void'(mq.pop_front());
        m_head = (m_head + 1) % N;
      end
    end
  endtask

  int pend_list[$];
  int pick;

  initial begin
    // fill & full, in-order retire after out-of-order resolve
    add(1,0,0, 0,0, 0,0,0,  0,0,0,0,0);
    add(0,1,1, 0,0, 0,0,0,  1,0,0,0,0);
    add(0,1,2, 0,0, 0,0,0,  1,1,1,0,0);
    add(0,1,3, 0,0, 0,0,0,  1,2,2,0,0);
    add(0,1,4, 0,0, 0,0,0,  1,3,3,0,0);
    add(0,1,5, 0,0, 0,0,0,  0,0,4,0,0);   // full: refused
    add(0,0,0, 0,0, 1,1,0,  0,0,4,0,0);
    add(0,0,0, 0,0, 1,0,0,  0,0,4,0,0);
    add(0,1,5, 0,0, 0,0,0,  0,0,4,0,0);   // retire this edge does not help
    add(0,0,0, 0,0, 0,0,0,  1,0,3,0,0);
    add(0,0,0, 0,0, 0,0,0,  1,0,2,0,0);
    // mispredict tag 1 from full
    add(1,0,0, 0,0, 0,0,0,  0,0,0,0,0);
    add(0,1,11,0,0, 0,0,0,  1,0,0,0,0);
    add(0,1,12,0,0, 0,0,0,  1,1,1,0,0);
    add(0,1,13,0,0, 0,0,0,  1,2,2,0,0);
    add(0,1,14,0,0, 0,0,0,  1,3,3,0,0);
    add(0,0,0, 0,0, 1,1,1,  0,0,4,0,0);
    add(0,1,15,0,0, 0,0,0,  0,1,1,1,12);  // recall cycle blocks alloc
    add(0,1,15,0,0, 0,0,0,  1,1,1,0,12);
    // mispredict tag 2 with a same-cycle allocation
    add(0,1,16,0,0, 0,0,0,  1,2,2,0,12);
    add(0,1,17,0,0, 0,0,0,  1,3,3,0,12);
    add(0,1,18,0,0, 1,2,1,  0,0,4,0,12);
    add(0,1,18,0,0, 0,0,0,  0,2,2,1,16);
    // back-to-back mispredicts: tag 3 then tag 1
    add(0,1,19,0,0, 0,0,0,  1,2,2,0,16);
    add(0,1,20,0,0, 0,0,0,  1,3,3,0,16);
    add(0,0,0, 0,0, 1,3,1,  0,0,4,0,16);
    add(0,0,0, 0,0, 1,1,1,  0,3,3,1,20);
    add(0,0,0, 0,0, 0,0,0,  0,1,1,1,15);
    // steady alloc/resolve/retire with tail wrap, then flush over mispredict
    add(0,1,21,0,0, 1,0,0,  1,1,1,0,15);
    add(0,1,22,0,0, 1,1,0,  1,2,2,0,15);
    add(0,1,23,0,0, 1,2,0,  1,3,2,0,15);
    add(0,1,24,0,0, 1,3,0,  1,0,2,0,15);
    add(0,1,25,0,0, 1,0,0,  1,1,2,0,15);
    add(0,0,0, 0,1, 1,1,1,  0,2,2,0,15);
    add(0,0,0, 0,0, 0,0,0,  1,0,0,0,15);
    add(0,1,26,1,0, 0,0,0,  0,0,0,0,15);  // stall blocks alloc
    add(0,0,0, 0,0, 0,0,0,  1,0,0,0,15);

    idle();
    reset_n = 0;
    repeat (2) @(posedge clk);
    #1;
    for (int r = 0; r < tv.size(); r++) begin
      reset_n            = !tv[r].rst;
      alloc_valid        = tv[r].av;
      checkpointed_rmt   = snap(tv[r].id);
      ext_stall          = tv[r].st;
      ext_flush          = tv[r].fl;
      resolve_valid      = tv[r].rv;
      resolve_tag        = CKPT_W'(tv[r].rt);
      resolve_mispredict = tv[r].rm;
      @(negedge clk);
      if (!tv[r].rst)
        check_outputs($sformatf("row%0d", r), tv[r].rdy, tv[r].tag, tv[r].cnt,
                      tv[r].rc, (tv[r].rid == 0) ? ident() : snap(tv[r].rid));
      @(posedge clk);
      #1;
    end

    // ---------------- random traffic vs model ----------------
    idle();
    reset_n = 0;
    @(posedge clk);
    #1;
    reset_n = 1;
    mq.delete(); m_head = 0; m_recall = 0; m_rmt = ident();
    for (int c = 0; c < 600; c++) begin
      alloc_valid = 1'($urandom_range(0, 1));
      ext_stall   = ($urandom_range(0, 9) == 0);
      ext_flush   = ($urandom_range(0, 39) == 0);
      for (int i = 0; i < NUM_ARCH_REGS; i++) checkpointed_rmt[i] = PR_W'($urandom);
      resolve_valid = 0; resolve_mispredict = 0; resolve_tag = '0;
      if ($urandom_range(0, 9) < 5) begin
        pend_list.delete();
        for (int k = 0; k < mq.size(); k++) if (!mq[k].resolved) pend_list.push_back(k);
        if (pend_list.size() > 0) begin
          pick               = pend_list[$urandom_range(0, pend_list.size() - 1)];
          resolve_valid      = 1;
          resolve_tag        = CKPT_W'((m_head + pick) % N);
          resolve_mispredict = ($urandom_range(0, 5) == 0);
        end
      end
      @(negedge clk);
      check_outputs($sformatf("rand%0d", c), m_ready(), (m_head + mq.size()) % N,
                    mq.size(), m_recall, m_rmt);
      @(posedge clk);
      model_step();
      #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish in time");
    $fatal(1);
  end

endmodule
